// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter draining per-producer result FIFOs (rs, lsb)
// into one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 rs_valid,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_value,
  output logic                 rs_stall,
  input  logic                 lsb_valid,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_value,
  output logic                 lsb_stall,
  output logic                 cdb_valid,
  output logic [ROB_WIDTH-1:0] cdb_rob_id,
  output logic [31:0]          cdb_value,
  output logic                 cdb_src
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ROB_WIDTH + 32;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [EW-1:0]        r_rs_mem  [FIFO_DEPTH];
  logic [EW-1:0]        r_lsb_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_rs_head, r_rs_tail, r_lsb_head, r_lsb_tail;
  logic [CW-1:0]        r_rs_count, r_lsb_count;
  logic                 r_last_grant;
  logic                 r_cdb_valid;
  logic [ROB_WIDTH-1:0] r_cdb_rob_id;
  logic [31:0]          r_cdb_value;
  logic                 r_cdb_src;

  logic          w_rs_push, w_lsb_push;
  logic          w_rs_nonempty, w_lsb_nonempty;
  logic          w_grant_rs, w_grant_lsb;
  logic          w_run;
  logic [EW-1:0] w_rs_head_entry, w_lsb_head_entry;

  assign rs_stall  = (r_rs_count == FULL);
  assign lsb_stall = (r_lsb_count == FULL);

  assign w_run      = rdy_in && !clear;
  assign w_rs_push  = rs_valid && !rs_stall;
  assign w_lsb_push = lsb_valid && !lsb_stall;

  // Grants see only registered counts, so a fresh push is never bypassed to the bus.
  assign w_rs_nonempty  = (r_rs_count != '0);
  assign w_lsb_nonempty = (r_lsb_count != '0);
  assign w_grant_rs     = w_rs_nonempty && (!w_lsb_nonempty || r_last_grant);
  assign w_grant_lsb    = w_lsb_nonempty && (!w_rs_nonempty || !r_last_grant);

  assign w_rs_head_entry  = r_rs_mem[r_rs_head];
  assign w_lsb_head_entry = r_lsb_mem[r_lsb_head];

  always_ff @(posedge clk_in) begin
    if (!rst_in && w_run && w_rs_push) begin
      r_rs_mem[r_rs_tail] <= {rs_rob_id, rs_value};
    end
    if (!rst_in && w_run && w_lsb_push) begin
      r_lsb_mem[r_lsb_tail] <= {lsb_rob_id, lsb_value};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rs_head    <= '0;
      r_rs_tail    <= '0;
      r_rs_count   <= '0;
      r_lsb_head   <= '0;
      r_lsb_tail   <= '0;
      r_lsb_count  <= '0;
      r_last_grant <= 1'b1;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= 1'b0;
    end else if (rdy_in) begin
      if (clear) begin
        r_rs_head    <= '0;
        r_rs_tail    <= '0;
        r_rs_count   <= '0;
        r_lsb_head   <= '0;
        r_lsb_tail   <= '0;
        r_lsb_count  <= '0;
        r_last_grant <= 1'b1;
        r_cdb_valid  <= 1'b0;
      end else begin
        if (w_rs_push) begin
          r_rs_tail <= r_rs_tail + PW'(1);
        end
        if (w_lsb_push) begin
          r_lsb_tail <= r_lsb_tail + PW'(1);
        end
        r_rs_count  <= r_rs_count + CW'(w_rs_push) - CW'(w_grant_rs);
        r_lsb_count <= r_lsb_count + CW'(w_lsb_push) - CW'(w_grant_lsb);

        if (w_grant_rs) begin
          r_rs_head    <= r_rs_head + PW'(1);
          r_last_grant <= 1'b0;
          r_cdb_valid  <= 1'b1;
          r_cdb_rob_id <= w_rs_head_entry[EW-1:32];
          r_cdb_value  <= w_rs_head_entry[31:0];
          r_cdb_src    <= 1'b0;
        end else if (w_grant_lsb) begin
          r_lsb_head   <= r_lsb_head + PW'(1);
          r_last_grant <= 1'b1;
          r_cdb_valid  <= 1'b1;
          r_cdb_rob_id <= w_lsb_head_entry[EW-1:32];
          r_cdb_value  <= w_lsb_head_entry[31:0];
          r_cdb_src    <= 1'b1;
        end else begin
          r_cdb_valid  <= 1'b0;
        end
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_value  = r_cdb_value;
  assign cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter: directed pushes, monitor checks each broadcast.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        src;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        rs_valid = 1'b0;
  logic [3:0]  rs_rob_id = '0;
  logic [31:0] rs_value = '0;
  logic        rs_stall;
  logic        lsb_valid = 1'b0;
  logic [3:0]  lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic        lsb_stall;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic        cdb_src;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic r_live = 1'b0;

  cdb_arbiter #(.ROB_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .rs_valid(rs_valid), .rs_rob_id(rs_rob_id), .rs_value(rs_value), .rs_stall(rs_stall),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_stall(lsb_stall),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_bc(input logic [3:0] rob, input logic [31:0] val, input logic src);
    exp_t e;
    e.rob = rob;
    e.val = val;
    e.src = src;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    rs_valid = 1'b0;
    lsb_valid = 1'b0;
    clear = 1'b0;
    rdy_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  // An edge only produces a new broadcast if it was a live (ready, non-reset) edge.
  always @(posedge clk_in) r_live <= rdy_in && !rst_in;

  always @(negedge clk_in) begin
    if (r_live && cdb_valid) begin
      if (sb.size() == 0) begin
        chk("cdb_unexpected_valid", {28'd0, cdb_rob_id}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cdb_rob_id", {28'd0, cdb_rob_id}, {28'd0, e.rob});
        chk("cdb_value", cdb_value, e.val);
        chk("cdb_src", {31'd0, cdb_src}, {31'd0, e.src});
      end
    end
  end

  initial begin
    int  ri;
    int  li;
    logic acc_r;
    logic acc_l;

    do_reset();
    chk("reset_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("reset_cdb_rob_id", {28'd0, cdb_rob_id}, 32'd0);
    chk("reset_cdb_value", cdb_value, 32'd0);
    chk("reset_cdb_src", {31'd0, cdb_src}, 32'd0);
    chk("reset_stalls", {30'd0, rs_stall, lsb_stall}, 32'd0);

    // single rs result: visible two edges after presentation
    expect_bc(4'd3, 32'h0000_00AA, 1'b0);
    rs_valid = 1'b1; rs_rob_id = 4'd3; rs_value = 32'h0000_00AA;
    step();
    rs_valid = 1'b0;
    chk("t1_no_bypass", {31'd0, cdb_valid}, 32'd0);
    step();
    chk("t1_valid_after_2", {31'd0, cdb_valid}, 32'd1);
    step();
    chk("t1_valid_drops", {31'd0, cdb_valid}, 32'd0);

    // simultaneous push: rs wins the tie after reset
    do_reset();
    expect_bc(4'd1, 32'h11, 1'b0);
    expect_bc(4'd2, 32'h22, 1'b1);
    rs_valid = 1'b1; rs_rob_id = 4'd1; rs_value = 32'h11;
    lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'h22;
    step();
    rs_valid = 1'b0; lsb_valid = 1'b0;
    repeat (3) step();

    // three rs entries in order, honouring stall
    for (int k = 0; k < 3; k++) expect_bc(4'(10 + k), 32'h300 + k, 1'b0);
    ri = 0;
    for (int c = 0; c < 10 && ri < 3; c++) begin
      rs_valid = 1'b1; rs_rob_id = 4'(10 + ri); rs_value = 32'h300 + ri;
      acc_r = !rs_stall;
      step();
      if (acc_r) ri++;
    end
    rs_valid = 1'b0;
    chk("t3_accepted", ri, 3);
    repeat (3) step();

    // both saturated for 8 cycles: strict alternation rs, lsb
    do_reset();
    for (int k = 0; k < 5; k++) begin
      expect_bc(4'(k), 32'h100 + k, 1'b0);
      expect_bc(4'(8 + k), 32'h200 + k, 1'b1);
    end
    ri = 0;
    li = 0;
    for (int c = 0; c < 8; c++) begin
      rs_valid = 1'b1; rs_rob_id = 4'(ri); rs_value = 32'h100 + ri;
      lsb_valid = 1'b1; lsb_rob_id = 4'(8 + li); lsb_value = 32'h200 + li;
      acc_r = !rs_stall;
      acc_l = !lsb_stall;
      step();
      if (acc_r) ri++;
      if (acc_l) li++;
    end
    rs_valid = 1'b0; lsb_valid = 1'b0;
    chk("t4_rs_accepted", ri, 5);
    chk("t4_lsb_accepted", li, 5);
    repeat (5) step();

    // clear flushes queued entries and the concurrent push
    do_reset();
    expect_bc(4'd1, 32'hA1, 1'b0);
    rs_valid = 1'b1; rs_rob_id = 4'd1; rs_value = 32'hA1;
    lsb_valid = 1'b1; lsb_rob_id = 4'd2; lsb_value = 32'hB2;
    step();
    rs_rob_id = 4'd3; rs_value = 32'hC3;
    lsb_rob_id = 4'd4; lsb_value = 32'hD4;
    step();
    chk("t5_lsb_full", {31'd0, lsb_stall}, 32'd1);
    lsb_valid = 1'b0;
    rs_rob_id = 4'd5; rs_value = 32'h55;
    clear = 1'b1;
    step();
    clear = 1'b0; rs_valid = 1'b0;
    chk("t5_clear_valid", {31'd0, cdb_valid}, 32'd0);
    chk("t5_clear_stalls", {30'd0, rs_stall, lsb_stall}, 32'd0);
    repeat (4) step();
    expect_bc(4'd6, 32'hE6, 1'b0);
    expect_bc(4'd7, 32'hF7, 1'b1);
    rs_valid = 1'b1; rs_rob_id = 4'd6; rs_value = 32'hE6;
    lsb_valid = 1'b1; lsb_rob_id = 4'd7; lsb_value = 32'hF7;
    step();
    rs_valid = 1'b0; lsb_valid = 1'b0;
    repeat (3) step();

    // reset mid-operation drops a queued entry
    rs_valid = 1'b1; rs_rob_id = 4'd9; rs_value = 32'h99;
    step();
    do_reset();
    repeat (2) step();

    // rdy_in low freezes everything
    expect_bc(4'd6, 32'h66, 1'b0);
    expect_bc(4'd7, 32'h77, 1'b0);
    rs_valid = 1'b1; rs_rob_id = 4'd6; rs_value = 32'h66;
    step();
    rs_rob_id = 4'd7; rs_value = 32'h77;
    step();
    rs_valid = 1'b0;
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t6_frozen_valid", {31'd0, cdb_valid}, 32'd1);
      chk("t6_frozen_rob", {28'd0, cdb_rob_id}, 32'd6);
      chk("t6_frozen_value", cdb_value, 32'h66);
    end
    rdy_in = 1'b1;
    step();
    chk("t6_resume_rob", {28'd0, cdb_rob_id}, 32'd7);
    chk("t6_resume_valid", {31'd0, cdb_valid}, 32'd1);
    step();
    chk("t6_idle_valid", {31'd0, cdb_valid}, 32'd0);
    repeat (3) step();

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
